// File: rtl/lsh_pkg.sv
// Shared types and constants for the LSH window front end.
//   nuc_e         : 2-bit nucleotide encoding (A=00 C=01 G=10 T=11)
//   state_e       : feeder FSM states
//   STROBE_CYCLES : length of every multi-cycle strobe
//   stride()      : beats between the starts of consecutive windows
package lsh_pkg;

   typedef enum logic [1:0] {
      NUC_A = 2'b00,
      NUC_C = 2'b01,
      NUC_G = 2'b10,
      NUC_T = 2'b11
   } nuc_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_FILL,
      S_HASH,
      S_COMMIT,
      S_GAP,
      S_RHASH,
      S_FINISH
   } state_e;

   localparam int unsigned STROBE_CYCLES = 2;

   // Consecutive windows overlap by kmer_size-1 nucleotides.
   function automatic int unsigned stride(input int unsigned window_size,
                                          input int unsigned kmer_size);
      return window_size - kmer_size + 1;
   endfunction

endpackage

// File: rtl/window_shift_buffer.sv
// Nucleotide shift register with a fill counter of programmable target.
//   clk, reset_n  : clock, async active-low reset
//   restart       : clear fill count and load target (held while not filling)
//   target        : beats needed to complete the next window
//   shift_en      : accepted beat, shifts data into the newest slot
//   data          : incoming nucleotide
//   window        : packed window, slot 0 (bits 1:0) is the oldest
//   fill_done_c   : this beat completes the window (combinational)
module window_shift_buffer
   import lsh_pkg::*;
#(
   parameter int unsigned WINDOW_SIZE = 128
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          restart,
   input  logic [$clog2(WINDOW_SIZE+1)-1:0] target,
   input  logic                          shift_en,
   input  nuc_e                          data,
   output logic [2*WINDOW_SIZE-1:0]      window,
   output logic                          fill_done_c
);

   localparam int unsigned CW = $clog2(WINDOW_SIZE + 1);

   logic [WINDOW_SIZE-1:0][1:0] slots;
   logic [CW-1:0]               count;
   logic [CW-1:0]               target_q;

   assign window      = slots;
   assign fill_done_c = shift_en && (count == target_q - CW'(1));

   // Shift register and fill counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slots    <= '0;
         count    <= '0;
         target_q <= CW'(WINDOW_SIZE);
      end else if (restart) begin
         count    <= '0;
         target_q <= target;
      end else if (shift_en) begin
         slots <= {data, slots[WINDOW_SIZE-1:1]};
         count <= fill_done_c ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/window_feeder.sv
// Serial nucleotide stream -> overlapping windows for the LSH engine.
//   clk, reset_n               : clock, async active-low reset
//   nuc_valid/data/last/ready  : upstream nucleotide stream handshake
//   is_reference               : stream type, sampled at stream start
//   window, window_id          : window to hasher and its index
//   ready_for_hashing          : hash request, held until hashing_is_done
//   reset_window_hasher        : hasher reset strobe
//   reset_stats                : query statistics reset strobe
//   is_insert / is_query       : commit strobes
//   calculate_matched_window   : end-of-read request
//   matched_window_id          : engine result (-1 = no match)
//   result_id, result_valid    : captured read result and its pulse
//   stream_done                : end-of-stream pulse
//   ref_overflow               : sticky, reference exceeded insert cap
module window_feeder
   import lsh_pkg::*;
#(
   parameter int unsigned WINDOW_SIZE              = 128,
   parameter int unsigned KMER_SIZE                = 16,
   parameter int unsigned MAX_WINDOWS_IN_REFERENCE = 512
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     nuc_valid,
   input  logic [1:0]               nuc_data,
   input  logic                     nuc_last,
   output logic                     nuc_ready,
   input  logic                     is_reference,
   output logic [2*WINDOW_SIZE-1:0] window,
   output logic [31:0]              window_id,
   output logic                     ready_for_hashing,
   input  logic                     hashing_is_done,
   output logic                     reset_window_hasher,
   output logic                     reset_stats,
   output logic                     is_insert,
   output logic                     is_query,
   output logic                     calculate_matched_window,
   input  logic signed [31:0]       matched_window_id,
   output logic signed [31:0]       result_id,
   output logic                     result_valid,
   output logic                     stream_done,
   output logic                     ref_overflow
);

   localparam int unsigned STRIDE_C = stride(WINDOW_SIZE, KMER_SIZE);
   localparam int unsigned CW       = $clog2(WINDOW_SIZE + 1);
   localparam int unsigned PW       = $clog2(STROBE_CYCLES + 1);

   state_e        state;
   logic [PW-1:0] phase;
   logic          stream_is_ref;
   logic          last_flag;
   logic          beat_c;
   logic          restart_c;
   logic [CW-1:0] target_c;
   logic          fill_done_c;
   logic          phase_end_c;

   assign beat_c      = nuc_valid && nuc_ready;
   assign phase_end_c = (phase == PW'(STROBE_CYCLES - 1));
   // Counter is re-armed while the hasher is being reset; first window needs a full fill.
   assign restart_c   = (state == S_START) || (state == S_RHASH);
   assign target_c    = (state == S_RHASH) ? CW'(STRIDE_C) : CW'(WINDOW_SIZE);

   window_shift_buffer #(
      .WINDOW_SIZE (WINDOW_SIZE)
   ) u_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .restart     (restart_c),
      .target      (target_c),
      .shift_en    (beat_c),
      .data        (nuc_e'(nuc_data)),
      .window      (window),
      .fill_done_c (fill_done_c)
   );

   // Feeder FSM; every strobe is set on entry to the state that owns it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                    <= S_IDLE;
         phase                    <= '0;
         stream_is_ref            <= 1'b0;
         last_flag                <= 1'b0;
         nuc_ready                <= 1'b0;
         window_id                <= '0;
         ready_for_hashing        <= 1'b0;
         reset_window_hasher      <= 1'b0;
         reset_stats              <= 1'b0;
         is_insert                <= 1'b0;
         is_query                 <= 1'b0;
         calculate_matched_window <= 1'b0;
         result_id                <= '1;
         result_valid             <= 1'b0;
         stream_done              <= 1'b0;
         ref_overflow             <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               result_valid <= 1'b0;
               stream_done  <= 1'b0;
               if (nuc_valid) begin
                  stream_is_ref       <= is_reference;
                  window_id           <= '0;
                  ref_overflow        <= 1'b0;
                  last_flag           <= 1'b0;
                  phase               <= '0;
                  reset_window_hasher <= 1'b1;
                  reset_stats         <= 1'b1;
                  state               <= S_START;
               end
            end

            S_START: begin
               if (phase_end_c) begin
                  phase               <= '0;
                  reset_window_hasher <= 1'b0;
                  reset_stats         <= 1'b0;
                  nuc_ready           <= 1'b1;
                  state               <= S_FILL;
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            S_FILL: begin
               if (beat_c) begin
                  if (fill_done_c) begin
                     nuc_ready         <= 1'b0;
                     ready_for_hashing <= 1'b1;
                     last_flag         <= nuc_last;
                     state             <= S_HASH;
                  end else if (nuc_last) begin
                     // Partial trailing window is dropped.
                     nuc_ready <= 1'b0;
                     phase     <= '0;
                     state     <= S_FINISH;
                     if (stream_is_ref) stream_done <= 1'b1;
                     else               calculate_matched_window <= 1'b1;
                  end
               end
            end

            S_HASH: begin
               if (hashing_is_done) begin
                  ready_for_hashing <= 1'b0;
                  phase             <= '0;
                  state             <= S_COMMIT;
                  if (stream_is_ref) begin
                     if (window_id >= 32'(MAX_WINDOWS_IN_REFERENCE)) ref_overflow <= 1'b1;
                     else                                            is_insert    <= 1'b1;
                  end else begin
                     is_query <= 1'b1;
                  end
               end
            end

            S_COMMIT: begin
               if (phase_end_c) begin
                  phase     <= '0;
                  is_insert <= 1'b0;
                  is_query  <= 1'b0;
                  state     <= S_GAP;
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            S_GAP: begin
               if (phase_end_c) begin
                  phase <= '0;
                  if (last_flag) begin
                     state <= S_FINISH;
                     if (stream_is_ref) stream_done <= 1'b1;
                     else               calculate_matched_window <= 1'b1;
                  end else begin
                     if (window_id != '1) window_id <= window_id + 32'd1;
                     reset_window_hasher <= 1'b1;
                     state               <= S_RHASH;
                  end
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            S_RHASH: begin
               if (phase_end_c) begin
                  phase               <= '0;
                  reset_window_hasher <= 1'b0;
                  nuc_ready           <= 1'b1;
                  state               <= S_FILL;
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            S_FINISH: begin
               if (stream_is_ref) begin
                  stream_done <= 1'b0;
                  state       <= S_IDLE;
               end else if (phase_end_c) begin
                  phase                    <= '0;
                  result_id                <= matched_window_id;
                  calculate_matched_window <= 1'b0;
                  result_valid             <= 1'b1;
                  stream_done              <= 1'b1;
                  state                    <= S_IDLE;
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_window_feeder.sv
// Self-checking bench for window_feeder: table of directed streams,
// randomized streams, and hand-written reset-during-hash sequence.
module tb_window_feeder;

   localparam int WS   = 128;
   localparam int KS   = 16;
   localparam int STR  = WS - KS + 1;
   localparam int MAXW = 4;

   logic                 clk;
   logic                 reset_n;
   logic                 nuc_valid;
   logic [1:0]           nuc_data;
   logic                 nuc_last;
   logic                 nuc_ready;
   logic                 is_reference;
   logic [2*WS-1:0]      window;
   logic [31:0]          window_id;
   logic                 ready_for_hashing;
   logic                 hashing_is_done;
   logic                 reset_window_hasher;
   logic                 reset_stats;
   logic                 is_insert;
   logic                 is_query;
   logic                 calculate_matched_window;
   logic signed [31:0]   matched_window_id;
   logic signed [31:0]   result_id;
   logic                 result_valid;
   logic                 stream_done;
   logic                 ref_overflow;

   window_feeder #(
      .WINDOW_SIZE              (WS),
      .KMER_SIZE                (KS),
      .MAX_WINDOWS_IN_REFERENCE (MAXW)
   ) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .nuc_valid                (nuc_valid),
      .nuc_data                 (nuc_data),
      .nuc_last                 (nuc_last),
      .nuc_ready                (nuc_ready),
      .is_reference             (is_reference),
      .window                   (window),
      .window_id                (window_id),
      .ready_for_hashing        (ready_for_hashing),
      .hashing_is_done          (hashing_is_done),
      .reset_window_hasher      (reset_window_hasher),
      .reset_stats              (reset_stats),
      .is_insert                (is_insert),
      .is_query                 (is_query),
      .calculate_matched_window (calculate_matched_window),
      .matched_window_id        (matched_window_id),
      .result_id                (result_id),
      .result_valid             (result_valid),
      .stream_done              (stream_done),
      .ref_overflow             (ref_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int exp_result = -1;
   logic [1:0] beats[$];

   typedef struct {
      bit is_ref;
      int n;
      int eng;
      int hdelay;   // <0: random 0..3 per window
      int exp_win;
   } vec_t;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [2*WS-1:0] act, input logic [2*WS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Window k covers stream positions k*STR .. k*STR+WS-1, slot 0 oldest.
   function automatic logic [2*WS-1:0] exp_window(input int k);
      logic [2*WS-1:0] w;
      w = '0;
      for (int i = 0; i < WS; i++) w[2*i +: 2] = beats[k*STR + i];
      return w;
   endfunction

   function automatic int model_windows(input int n);
      return (n >= WS) ? 1 + (n - WS) / STR : 0;
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_nuc_ready"}, nuc_ready, 0);
      chk({tag, "_rfh"}, ready_for_hashing, 0);
      chk({tag, "_window_id"}, window_id, 0);
      chk_w({tag, "_window"}, window, '0);
      chk({tag, "_result_id"}, result_id, -1);
      chk({tag, "_ref_overflow"}, ref_overflow, 0);
      chk({tag, "_strobes"}, {reset_window_hasher, reset_stats, is_insert, is_query,
                              calculate_matched_window, result_valid, stream_done}, 0);
   endtask

   task automatic run_stream(input bit ref_s, input int n, input int eng,
                             input int hdelay, input int nw_exp);
      int ptr = 0, win_cnt = 0, ins = 0, qry = 0, cmw_cyc = 0, rv = 0, sd = 0;
      int rfh_len = 0, hd = 0, cm = 0, cyc = 0;
      bit acc, prev_rfh = 0, prev_cmw = 0, finished = 0, unstable = 0, ready_in_hash = 0;
      logic [2*WS-1:0] held = '0;
      int exp_ins;

      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back(2'($urandom_range(0, 3)));

      @(negedge clk);
      is_reference = ref_s;
      nuc_valid    = 1'b1;
      nuc_data     = beats[0];
      nuc_last     = (n == 1);
      acc          = nuc_valid && nuc_ready;

      while (!finished && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (acc) ptr++;

         if (ready_for_hashing && !prev_rfh) begin
            if (win_cnt < nw_exp) chk_w("window_content", window, exp_window(win_cnt));
            else                  chk("extra_window", win_cnt, nw_exp - 1);
            chk("window_id", window_id, win_cnt);
            held    = window;
            rfh_len = 0;
            hd      = (hdelay < 0) ? int'($urandom_range(0, 3)) : hdelay;
         end
         if (ready_for_hashing) begin
            rfh_len++;
            if (nuc_ready) ready_in_hash = 1;
         end
         if (!ready_for_hashing && prev_rfh) begin
            chk("rfh_len", rfh_len, hd + 1);
            win_cnt++;
         end
         if ((ready_for_hashing || is_insert || is_query) && window !== held) unstable = 1;

         ins     += int'(is_insert);
         qry     += int'(is_query);
         cmw_cyc += int'(calculate_matched_window);
         if (result_valid) begin
            rv++;
            chk("rv_with_done", stream_done, 1);
            chk("rv_after_cmw", {prev_cmw, calculate_matched_window}, 2'b10);
            chk("result_id", result_id, eng);
         end
         if (stream_done) begin
            sd++;
            finished = 1;
         end
         prev_rfh = ready_for_hashing;
         prev_cmw = calculate_matched_window;

         // Engine side
         hashing_is_done   = ready_for_hashing ? (rfh_len > hd) : 1'($urandom_range(0, 1));
         cm                = calculate_matched_window ? cm + 1 : 0;
         matched_window_id = (cm == 2) ? eng : $urandom;

         // Source side
         if (ptr < n) begin
            nuc_valid = ($urandom_range(0, 3) != 0);
            nuc_data  = beats[ptr];
            nuc_last  = (ptr == n - 1);
         end else begin
            nuc_valid = 1'b0;
            nuc_data  = 2'($urandom_range(0, 3));
            nuc_last  = 1'b0;
         end
         acc = nuc_valid && nuc_ready;
      end
      chk("stream_done_seen", finished, 1);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rv += int'(result_valid);
         sd += int'(stream_done);
      end

      if (!ref_s) exp_result = eng;
      exp_ins = ref_s ? 2 * ((nw_exp > MAXW) ? MAXW : nw_exp) : 0;
      chk("windows", win_cnt, nw_exp);
      chk("insert_cycles", ins, exp_ins);
      chk("query_cycles", qry, ref_s ? 0 : 2 * nw_exp);
      chk("cmw_cycles", cmw_cyc, ref_s ? 0 : 2);
      chk("result_valid_pulses", rv, ref_s ? 0 : 1);
      chk("stream_done_pulses", sd, 1);
      chk("beats_consumed", ptr, n);
      chk("ref_overflow", ref_overflow, (ref_s && nw_exp > MAXW) ? 1 : 0);
      chk("result_id_hold", result_id, exp_result);
      chk("window_stable", unstable, 0);
      chk("ready_low_in_hash", ready_in_hash, 0);
   endtask

   initial begin
      vec_t tbl[10];
      int   cyc;

      tbl[0] = '{1, 128,  0, -1, 1};
      tbl[1] = '{1, 241,  0, -1, 2};
      tbl[2] = '{0, 200,  5, -1, 1};
      tbl[3] = '{0,  50, -1, -1, 0};
      tbl[4] = '{0, 128,  7, 20, 1};
      tbl[5] = '{1, 127,  0, -1, 0};
      tbl[6] = '{0, 354, 42,  0, 3};
      tbl[7] = '{0, 353, -1, -1, 2};
      tbl[8] = '{1, 693,  0, -1, 6};
      tbl[9] = '{0,   1, 13, -1, 0};

      reset_n           = 1'b0;
      nuc_valid         = 1'b0;
      nuc_data          = 2'b00;
      nuc_last          = 1'b0;
      is_reference      = 1'b0;
      hashing_is_done   = 1'b0;
      matched_window_id = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_values("post_reset");

      foreach (tbl[i]) run_stream(tbl[i].is_ref, tbl[i].n, tbl[i].eng, tbl[i].hdelay, tbl[i].exp_win);

      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(1, 400));
         run_stream(1'($urandom_range(0, 1)), n, int'($urandom), -1, model_windows(n));
      end

      // Reset asserted while waiting for the hasher, then a clean stream.
      @(negedge clk);
      is_reference    = 1'b1;
      nuc_valid       = 1'b1;
      hashing_is_done = 1'b0;
      cyc = 0;
      while (!ready_for_hashing && cyc < 400) begin
         nuc_data = 2'($urandom_range(0, 3));
         @(negedge clk);
         cyc++;
      end
      chk("reset_seq_reached_hash", ready_for_hashing, 1);
      #2 reset_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      nuc_valid = 1'b0;
      @(negedge clk);
      reset_n    = 1'b1;
      exp_result = -1;
      run_stream(1'b1, 128, 0, -1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
